// File: rtl/wb_req_arbiter.sv
// wb_req_arbiter
// Shares one Wishbone classic master port between NREQ requesters. A
// round-robin search picks one requester per idle cycle. Its command is
// latched onto the bus, and the cycle stays open until the slave responds
// or the watchdog expires. The result then goes back to that requester.
//
// Ports
//   wb_clk, wb_rst       clock, synchronous active-high reset
//   req_i                per-requester request level
//   req_adr_i/dat_i/     packed per-requester command fields
//   sel_i/we_i             (requester n at [n*width +: width])
//   gnt_o                one-hot grant, high for the whole bus cycle
//   done_o, err_o        one-cycle completion / error pulses
//   rd_dat_o             read data of the last successful read
//   busy_o               high while a bus cycle is open
//   wb_*_o               registered Wishbone master outputs
//   wb_dat_i, wb_ack_i,  Wishbone slave responses
//   wb_err_i, wb_rty_i
module wb_req_arbiter #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic               wb_clk,
    input  logic               wb_rst,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*aw-1:0] req_adr_i,
    input  logic [NREQ*dw-1:0] req_dat_i,
    input  logic [NREQ*4-1:0]  req_sel_i,
    input  logic [NREQ-1:0]    req_we_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    done_o,
    output logic [NREQ-1:0]    err_o,
    output logic [dw-1:0]      rd_dat_o,
    output logic               busy_o,
    output logic [aw-1:0]      wb_adr_o,
    output logic [dw-1:0]      wb_dat_o,
    output logic [3:0]         wb_sel_o,
    output logic               wb_we_o,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic [2:0]         wb_cti_o,
    output logic [1:0]         wb_bte_o,
    input  logic [dw-1:0]      wb_dat_i,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    input  logic               wb_rty_i
);

    localparam int              IW       = $clog2(NREQ);
    localparam logic [0:0]      ST_IDLE  = 1'b0;
    localparam logic [0:0]      ST_BUS   = 1'b1;
    localparam logic [15:0]     CNT_LAST = 16'(TIMEOUT - 1);
    localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    logic [0:0]      state_r;
    logic [IW-1:0]   last_r;
    logic [15:0]     cnt_r;
    logic [NREQ-1:0] mask_r;
    logic [NREQ-1:0] gnt_r;
    logic [NREQ-1:0] done_r;
    logic [NREQ-1:0] err_r;
    logic [dw-1:0]   rd_dat_r;
    logic [aw-1:0]   adr_r;
    logic [dw-1:0]   dat_r;
    logic [3:0]      sel_r;
    logic            we_r;

    logic [NREQ-1:0] eligible_s;
    logic            found_s;
    logic [IW-1:0]   win_s;
    logic [IW-1:0]   idx_s;
    logic            term_s;
    logic            term_err_s;

    // Round-robin search starting just after the last winner; the requester
    // served in the previous cycle is masked for one idle cycle.
    always_comb begin
        eligible_s = req_i & ~mask_r;
        found_s    = 1'b0;
        win_s      = '0;
        idx_s      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = IW'((int'(last_r) + k) % NREQ);
            if (!found_s && eligible_s[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Bus-cycle termination in priority order: err/rty, ack, watchdog.
    always_comb begin
        if (wb_err_i || wb_rty_i) begin
            term_s     = 1'b1;
            term_err_s = 1'b1;
        end else if (wb_ack_i) begin
            term_s     = 1'b1;
            term_err_s = 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            term_s     = 1'b1;
            term_err_s = 1'b1;
        end else begin
            term_s     = 1'b0;
            term_err_s = 1'b0;
        end
    end

    // Sequencer: grants in IDLE, holds the frozen command in BUS and retires it.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_r  <= ST_IDLE;
            last_r   <= LAST_RST;
            cnt_r    <= 16'd0;
            mask_r   <= '0;
            gnt_r    <= '0;
            done_r   <= '0;
            err_r    <= '0;
            rd_dat_r <= '0;
            adr_r    <= '0;
            dat_r    <= '0;
            sel_r    <= 4'h0;
            we_r     <= 1'b0;
        end else begin
            done_r <= '0;
            err_r  <= '0;
            case (state_r)
                ST_IDLE: begin
                    mask_r <= '0;
                    if (found_s) begin
                        state_r <= ST_BUS;
                        last_r  <= win_s;
                        cnt_r   <= 16'd0;
                        gnt_r   <= ONE_HOT0 << win_s;
                        adr_r   <= req_adr_i[int'(win_s)*aw +: aw];
                        dat_r   <= req_dat_i[int'(win_s)*dw +: dw];
                        sel_r   <= req_sel_i[int'(win_s)*4 +: 4];
                        we_r    <= req_we_i[win_s];
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUS: begin
                    if (term_s) begin
                        state_r <= ST_IDLE;
                        gnt_r   <= '0;
                        adr_r   <= '0;
                        dat_r   <= '0;
                        sel_r   <= 4'h0;
                        we_r    <= 1'b0;
                        done_r  <= ONE_HOT0 << last_r;
                        err_r   <= term_err_s ? (ONE_HOT0 << last_r) : '0;
                        mask_r  <= ONE_HOT0 << last_r;
                        if (!term_err_s && !we_r) begin
                            rd_dat_r <= wb_dat_i;
                        end else begin
                            rd_dat_r <= rd_dat_r;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o    = gnt_r;
    assign done_o   = done_r;
    assign err_o    = err_r;
    assign rd_dat_o = rd_dat_r;
    assign busy_o   = (state_r == ST_BUS);
    assign wb_adr_o = adr_r;
    assign wb_dat_o = dat_r;
    assign wb_sel_o = sel_r;
    assign wb_we_o  = we_r;
    assign wb_cyc_o = (state_r == ST_BUS);
    assign wb_stb_o = (state_r == ST_BUS);
    // Only classic single transfers are issued.
    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

endmodule
